// File: rtl/mem_responder.sv
// Memory-side bus responder: on-chip word array behind MAB/MDB with programmable
// wait states, a one-cycle mfc completion pulse and an err qualifier.
module mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] MAB,
    inout  wire  [15:0] MDB,
    input  logic        rd,
    input  logic        wr,
    output logic        mfc,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP, HOLD} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_t;

    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_t            state, state_nxt;
    op_t               op;
    logic [ADDR_W-1:0] idx;
    logic [15:0]       wdata;
    logic [15:0]       rdata;
    logic              lerr;
    logic [3:0]        cnt;
    logic [15:0]       mem [DEPTH];

    logic [ADDR_W-1:0] req_idx;
    logic              req_err;
    logic              start;
    logic              finish;
    logic              drive;

    assign req_idx = MAB[ADDR_W:1];
    assign req_err = MAB[0] | ((MAB >> (ADDR_W + 1)) != 16'd0);

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (rd || wr) begin
                    state_nxt = BUSY;
                    start     = 1'b1;
                end
            end
            BUSY: begin
                if (!rd && !wr) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = RESP;
                    finish    = 1'b1;
                end
            end
            RESP:    state_nxt = HOLD;
            HOLD:    if (!rd && !wr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op    <= OP_NONE;
            idx   <= '0;
            wdata <= '0;
            rdata <= '0;
            lerr  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                cnt   <= 4'(WAIT_STATES);
                idx   <= req_idx;
                wdata <= MDB;
                // Simultaneous rd/wr is answered as an error with no access.
                if (rd && wr) begin
                    op   <= OP_NONE;
                    lerr <= 1'b1;
                end else begin
                    op   <= rd ? OP_READ : OP_WRITE;
                    lerr <= req_err;
                end
            end else if (state == BUSY && state_nxt == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (finish) begin
                rdata <= (op == OP_READ && !lerr) ? mem[idx] : '0;
            end
        end
    end

    // Array has no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (finish && op == OP_WRITE && !lerr) begin
            mem[idx] <= wdata;
        end
    end

    assign mfc   = (state == RESP);
    assign err   = mfc & lerr;
    assign drive = (state == RESP || state == HOLD) && op == OP_READ && rd;
    assign MDB   = drive ? rdata : 'z;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, multi-cycle corner
// sequences and randomized traffic against an associative-array memory model.
module tb_mem_responder;
    localparam int unsigned W_MAIN = 2;
    localparam int unsigned W_FAST = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] mab_a, dat_a, mab_b, dat_b;
    logic        rd_a, wr_a, en_a, rd_b, wr_b, en_b;
    wire  [15:0] mdb_a, mdb_b;
    logic        mfc_a, err_a, mfc_b, err_b;

    assign mdb_a = en_a ? dat_a : 'z;
    assign mdb_b = en_b ? dat_b : 'z;

    mem_responder #(.ADDR_W(8), .WAIT_STATES(W_MAIN)) dut (
        .clk(clk), .rst(rst), .MAB(mab_a), .MDB(mdb_a),
        .rd(rd_a), .wr(wr_a), .mfc(mfc_a), .err(err_a)
    );

    mem_responder #(.ADDR_W(4), .WAIT_STATES(W_FAST)) dut_fast (
        .clk(clk), .rst(rst), .MAB(mab_b), .MDB(mdb_b),
        .rd(rd_b), .wr(wr_b), .mfc(mfc_b), .err(err_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] model [int];

    typedef struct {
        logic        r;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic        e;
        logic [15:0] q;
    } vec_t;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_released(input string name, input logic [15:0] bus);
        n_vec++;
        if (!(bus === 16'hzzzz || bus === 16'h0000)) begin
            n_bad++;
            $display("FAIL %s: bus %h expected released", name, bus);
        end
    endtask

    function automatic logic cur_mfc(input bit fast);
        return fast ? mfc_b : mfc_a;
    endfunction

    function automatic logic cur_err(input bit fast);
        return fast ? err_b : err_a;
    endfunction

    function automatic logic [15:0] cur_bus(input bit fast);
        return fast ? mdb_b : mdb_a;
    endfunction

    task automatic drive(input bit fast, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (fast) begin
            rd_b = r; wr_b = w; mab_b = a; dat_b = d; en_b = w & ~r;
        end else begin
            rd_a = r; wr_a = w; mab_a = a; dat_a = d; en_a = w & ~r;
        end
    endtask

    // One full request/response handshake, checking latency, pulse width, err and bus.
    task automatic do_req(input bit fast, input string tag, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d,
                          input logic exp_err, input logic [15:0] exp_q);
        int unsigned lat;
        int unsigned exp_lat;
        bit          seen;
        exp_lat = (fast ? W_FAST : W_MAIN) + 2;
        @(negedge clk);
        drive(fast, r, w, a, d);
        @(posedge clk);
        seen = 1'b0;
        lat  = 0;
        for (int unsigned c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (cur_mfc(fast)) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s timeout: no mfc within 40 cycles", tag);
            drive(fast, 1'b0, 1'b0, a, d);
            return;
        end
        check({tag, " latency"}, 16'(lat), 16'(exp_lat));
        check({tag, " err"}, {15'd0, cur_err(fast)}, {15'd0, exp_err});
        if (r && !w)      check({tag, " rdata"}, cur_bus(fast), exp_q);
        else if (w && !r) check({tag, " wr bus"}, cur_bus(fast), d);
        else              check_released({tag, " rdwr bus"}, cur_bus(fast));
        @(negedge clk);
        check({tag, " mfc pulse"}, {15'd0, cur_mfc(fast)}, 16'd0);
        if (r && !w) check({tag, " hold rdata"}, cur_bus(fast), exp_q);
        drive(fast, 1'b0, 1'b0, a, d);
        #1;
        if (r && !w) check_released({tag, " release"}, cur_bus(fast));
        if (w && !r && !exp_err && !fast) model[int'(a) / 2] = d;
    endtask

    function automatic logic addr_bad(input logic [15:0] a, input int unsigned depth);
        return (int'(a) % 2 != 0) || (int'(a) / 2 >= int'(depth));
    endfunction

    initial begin
        vec_t tbl [13];
        bit   seen;

        tbl[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
        tbl[2]  = '{1'b0, 1'b1, 16'h0000, 16'h1234, 1'b0, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'h0000};
        tbl[4]  = '{1'b0, 1'b1, 16'h0400, 16'hDEAD, 1'b1, 16'h0000};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1234};
        tbl[6]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1234};
        tbl[8]  = '{1'b0, 1'b1, 16'h01FE, 16'h5A5A, 1'b0, 16'h0000};
        tbl[9]  = '{1'b1, 1'b0, 16'h01FE, 16'h0000, 1'b0, 16'h5A5A};
        tbl[10] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 16'h0000};
        tbl[11] = '{1'b0, 1'b1, 16'h8000, 16'h7777, 1'b1, 16'h0000};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1234};

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        check("reset mfc", {15'd0, mfc_a}, 16'd0);
        check("reset err", {15'd0, err_a}, 16'd0);
        check_released("reset bus", mdb_a);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            do_req(1'b0, $sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d,
                   tbl[i].e, tbl[i].q);
        end

        // Write abandoned during the wait states must not complete or modify memory.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 16'h0010, 16'h1111);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0010, 16'h1111);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mfc_a) seen = 1'b1;
        end
        check("abort no mfc", {15'd0, seen}, 16'd0);
        do_req(1'b0, "abort readback", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF);

        // Asynchronous reset while read data is on the bus.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 16'h01FE, 16'h0000);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (mfc_a) seen = 1'b1;
        end
        check("rst-seq mfc seen", {15'd0, seen}, 16'd1);
        @(negedge clk);
        check("rst-seq hold data", mdb_a, 16'h5A5A);
        #2 rst = 1'b0;
        #1;
        check_released("rst-seq bus", mdb_a);
        check("rst-seq mfc", {15'd0, mfc_a}, 16'd0);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        do_req(1'b0, "post-rst rd hi", 1'b1, 1'b0, 16'h01FE, 16'h0000, 1'b0, 16'h5A5A);
        do_req(1'b0, "post-rst rd 0", 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1234);

        // Zero-wait-state instance with a 16-word array.
        do_req(1'b1, "fast wr", 1'b0, 1'b1, 16'h0006, 16'h7E7E, 1'b0, 16'h0000);
        do_req(1'b1, "fast rd", 1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 16'h7E7E);
        do_req(1'b1, "fast oor", 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h0000);
        do_req(1'b1, "fast top wr", 1'b0, 1'b1, 16'h001E, 16'hC3C3, 1'b0, 16'h0000);
        do_req(1'b1, "fast top rd", 1'b1, 1'b0, 16'h001E, 16'h0000, 1'b0, 16'hC3C3);

        for (int n = 0; n < 150; n++) begin
            logic [15:0] a;
            logic [15:0] d;
            logic        r, w, e;
            logic [15:0] q;
            int unsigned kind;
            d    = 16'($urandom);
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) begin
                a = 16'($urandom);
                if (!addr_bad(a, 256)) a = a | 16'h8000;
            end else begin
                a = 16'($urandom_range(0, 15) * 2);
            end
            r = (kind < 5) || (kind == 9);
            w = (kind >= 5);
            e = addr_bad(a, 256) || (r && w);
            if (r && !w && !e && !model.exists(int'(a) / 2)) begin
                r = 1'b0;
                w = 1'b1;
            end
            q = 16'h0000;
            if (r && !w && !e) q = model[int'(a) / 2];
            do_req(1'b0, $sformatf("rand%0d", n), r, w, a, d, e, q);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU memory bus.
- Serves word read/write requests that the datapath issues on MAB (address) and MDB (bidirectional data).
- Holds a parameterized on-chip word array, inserts programmable wait states, and signals completion with a one-cycle mfc pulse.
- Drives MDB only while returning read data. It sits between the multi-cycle CPU and the rest of the system as the only memory target.

Parameters:
- ADDR_W, 8: word-address width; array depth = 2^ADDR_W 16-bit words.
- WAIT_STATES, 2: extra cycles inserted before completion (0..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- MAB  input  16  byte address from the CPU. Words are 16-bit, so MAB[0] must be 0.
- MDB  inout  16  data bus. The CPU drives it for writes; this block drives it for reads; otherwise high-Z.
- rd  input  1  read request, level; the CPU holds it until it sees mfc.
- wr  input  1  write request, level; the CPU holds it, with MAB/MDB stable, until it sees mfc.
- mfc  output  1  memory-function-complete, one-cycle pulse.
- err  output  1  error qualifier, valid only while mfc=1.

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - state=IDLE, mfc=0, err=0, MDB released (high-Z), wait counter=0.
  - Array contents are not cleared and survive reset; contents are undefined at power-up.
- Decode: word index = MAB[ADDR_W:1]. The access is in range iff MAB[15:ADDR_W+1]==0 and MAB[0]==0; otherwise it is an error.
- FSM states: IDLE, BUSY, RESP, HOLD.
- IDLE:
  - rd xor wr high at an edge: latch op, MAB, MDB (write data) and error status; cnt<=WAIT_STATES; go BUSY.
  - rd and wr both high: latch err=1 and op=none; go BUSY (normal timing, no access).
- BUSY:
  - If the active request is deasserted (rd=wr=0): abort, go IDLE. No write, no mfc.
  - Else if cnt==0, go RESP:
    - Read: register array[index] into rdata (16'h0000 if error).
    - Write without error: array[index]<=latched data.
  - Else cnt<=cnt-1.
- RESP:
  - mfc=1 and err=latched error for exactly this cycle.
  - MDB driven with rdata if op=read.
  - Always go HOLD at the next edge.
- HOLD:
  - mfc=0.
  - MDB stays driven with rdata while op=read and rd=1; it is released in the same cycle rd falls (combinational enable).
  - Go IDLE when rd=wr=0.
- Latency: request sampled at edge E0; mfc high in the cycle following edge E0+WAIT_STATES+1. With WAIT_STATES=0, mfc rises one cycle after the sampling edge.
- Bus discipline:
  - MDB output enable = (state==RESP or HOLD) and op==read and rd. Never driven during writes, in IDLE/BUSY, or during reset.
  - New requests are accepted only in IDLE. Back-to-back requests therefore need the request to drop for at least one cycle.
- Errors:
  - Misaligned or out-of-range writes leave the array unchanged.
  - Errored reads return 16'h0000 with err=1.
  - rd and wr together: err=1, no access, MDB not driven.
- Latched values: op and address are frozen from IDLE sampling. MAB/MDB changes during BUSY do not affect the access.

Test Plan:
- WAIT_STATES=2, write MAB=16'h0010 MDB=16'hBEEF with wr held -> mfc pulses one cycle, 3 cycles after the sampling edge, err=0. MDB not driven by the block throughout.
- Read MAB=16'h0010 with rd held -> mfc with err=0, MDB=16'hBEEF from the mfc cycle until rd drops, then high-Z the same cycle.
- Read MAB=16'h0011 (misaligned) and write MAB=16'h0400 (out of range for ADDR_W=8) -> mfc with err=1; read returns 16'h0000. A subsequent read of word 0 shows prior contents unchanged.
- rd and wr asserted together -> mfc with err=1, MDB high-Z, no array change.
- Write issued, then rd/wr dropped during BUSY -> no mfc, FSM back in IDLE; a readback shows the old data.
- Assert rst=0 asynchronously in HOLD while driving read data -> MDB immediately high-Z, mfc=0. After release, data written before reset reads back intact. WAIT_STATES=0 build gives mfc one cycle after the request edge.
